// File: rtl/n_clic_tc_if.sv
// n_clic_tc_if: indexed configuration port for the n_clic_tc interrupt controller
interface n_clic_tc_if #(parameter int VecCount = 16) ();
  localparam int IW = $clog2(VecCount);
  logic          cfg_we;
  logic [IW-1:0] cfg_idx;
  logic [1:0]    cfg_field;
  logic [31:0]   cfg_wdata;
  logic [31:0]   cfg_rdata;
  modport master (output cfg_we, cfg_idx, cfg_field, cfg_wdata, input cfg_rdata);
  modport slave (input cfg_we, cfg_idx, cfg_field, cfg_wdata, output cfg_rdata);
endinterface

// File: rtl/n_clic_tc.sv
// n_clic_tc: nested vectored interrupt controller with return stack, tail-chaining and config port
module n_clic_tc #(
  parameter int VecCount   = 16,
  parameter int PrioWidth  = 3,
  parameter int StackDepth = 4,
  parameter int PcWidth    = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [VecCount-1:0]               pend_i,
  n_clic_tc_if.slave                        cfg,
  input  logic [PcWidth-1:0]                pc_in,
  input  logic                              mret_i,
  output logic [PcWidth-1:0]                pc_out,
  output logic                              take_o,
  output logic [PrioWidth-1:0]              level_o,
  output logic [$clog2(StackDepth+1)-1:0]   depth_o,
  output logic                              err_o
);
  localparam int IW = $clog2(VecCount);
  localparam int DW = $clog2(StackDepth + 1);
  localparam int SW = StackDepth > 1 ? $clog2(StackDepth) : 1;
  logic [VecCount-1:0]  pending, enable;
  logic [PrioWidth-1:0] prio [VecCount];
  logic [PcWidth-1:0]   vaddr [VecCount];
  logic [PcWidth-1:0]   stk_pc [StackDepth];
  logic [PrioWidth-1:0] stk_lvl [StackDepth];
  logic [PrioWidth-1:0] thr, level, max_prio, top_lvl, eff, eff_tc;
  logic [DW-1:0]        depth;
  logic [IW-1:0]        max_vec;
  logic [SW-1:0]        top, push;
  logic                 err, found, preempt, chain, pop;
  logic                 unused_wdata;
  // strict '>' keeps the lowest index among equal priorities
  always_comb begin
    found    = 1'b0;
    max_prio = '0;
    max_vec  = '0;
    for (int i = 0; i < VecCount; i++)
      if (pending[i] && enable[i] && (!found || prio[i] > max_prio)) begin
        found    = 1'b1;
        max_prio = prio[i];
        max_vec  = IW'(i);
      end
  end
  assign top     = SW'(depth - 1'b1);
  assign push    = SW'(depth);
  assign top_lvl = stk_lvl[top];
  assign eff     = level > thr ? level : thr;
  assign eff_tc  = top_lvl > thr ? top_lvl : thr;
  assign preempt = !mret_i && found && max_prio > eff && depth < DW'(StackDepth);
  // tail-chain reuses the saved pc, so the stack is left untouched
  assign chain   = mret_i && depth != '0 && found && max_prio > eff_tc;
  assign pop     = mret_i && depth != '0 && !chain;
  assign take_o  = preempt || chain;
  assign pc_out  = take_o ? vaddr[max_vec] : pop ? stk_pc[top] : pc_in;
  assign level_o = level;
  assign depth_o = depth;
  assign err_o   = err;
  assign unused_wdata = ^cfg.cfg_wdata;
  always_comb
    cfg.cfg_rdata = cfg.cfg_field == 2'd0 ? 32'({prio[cfg.cfg_idx], enable[cfg.cfg_idx], pending[cfg.cfg_idx]}) :
                    cfg.cfg_field == 2'd1 ? 32'(vaddr[cfg.cfg_idx]) :
                    cfg.cfg_field == 2'd2 ? 32'(thr) : 32'd0;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pending <= '0;
      enable  <= '0;
      thr     <= '0;
      level   <= '0;
      depth   <= '0;
      err     <= 1'b0;
      for (int i = 0; i < VecCount; i++) begin
        prio[i]  <= '0;
        vaddr[i] <= '0;
      end
      for (int i = 0; i < StackDepth; i++) begin
        stk_pc[i]  <= '0;
        stk_lvl[i] <= '0;
      end
    end else begin
      for (int i = 0; i < VecCount; i++)
        if (cfg.cfg_we && cfg.cfg_field == 2'd0 && cfg.cfg_idx == IW'(i)) begin
          pending[i] <= cfg.cfg_wdata[0];
          enable[i]  <= cfg.cfg_wdata[1];
          prio[i]    <= cfg.cfg_wdata[2+:PrioWidth];
        end else if (pend_i[i])
          pending[i] <= 1'b1;
        else if (take_o && max_vec == IW'(i))
          pending[i] <= 1'b0;
      if (cfg.cfg_we && cfg.cfg_field == 2'd1)
        vaddr[cfg.cfg_idx] <= cfg.cfg_wdata[PcWidth-1:0];
      if (cfg.cfg_we && cfg.cfg_field == 2'd2)
        thr <= cfg.cfg_wdata[PrioWidth-1:0];
      if (preempt) begin
        stk_pc[push]  <= pc_in;
        stk_lvl[push] <= level;
        depth         <= depth + 1'b1;
      end else if (pop)
        depth <= depth - 1'b1;
      if (take_o)
        level <= max_prio;
      else if (pop)
        level <= top_lvl;
      if (mret_i && depth == '0)
        err <= 1'b1;
    end
endmodule

// File: tb/tb_n_clic_tc.sv
// tb_n_clic_tc: directed self-checking bench for n_clic_tc
module tb_n_clic_tc;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] pend_i = '0;
  logic [15:0] pc_in = '0;
  logic        mret_i = 1'b0;
  logic [15:0] pc_out;
  logic        take_o;
  logic [2:0]  level_o;
  logic [2:0]  depth_o;
  logic        err_o;
  logic [31:0] rd;
  int          n_chk = 0;
  int          n_err = 0;
  n_clic_tc_if #(.VecCount(16)) c ();
  n_clic_tc dut (
    .clk(clk), .reset(reset), .pend_i(pend_i), .cfg(c.slave), .pc_in(pc_in),
    .mret_i(mret_i), .pc_out(pc_out), .take_o(take_o), .level_o(level_o),
    .depth_o(depth_o), .err_o(err_o));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic cfg_wr(input logic [1:0] f, input logic [3:0] i, input logic [31:0] d);
    c.cfg_we = 1'b1;
    c.cfg_field = f;
    c.cfg_idx = i;
    c.cfg_wdata = d;
    tick();
    c.cfg_we = 1'b0;
  endtask
  task automatic entry(input logic [3:0] v, input logic [2:0] p, input logic [15:0] addr);
    cfg_wr(2'd0, v, {27'd0, p, 2'b10});
    cfg_wr(2'd1, v, {16'd0, addr});
  endtask
  task automatic cfg_rd(input logic [1:0] f, input logic [3:0] i);
    c.cfg_field = f;
    c.cfg_idx = i;
    #1 rd = c.cfg_rdata;
  endtask
  task automatic pend(input int v);
    pend_i[v] = 1'b1;
    tick();
    pend_i = '0;
    #1;
  endtask
  initial begin
    c.cfg_we = 1'b0;
    c.cfg_field = '0;
    c.cfg_idx = '0;
    c.cfg_wdata = '0;
    pc_in = 16'd55;
    tick();
    tick();
    check("rst_take", take_o, 0);
    check("rst_pc", pc_out, 55);
    check("rst_depth", depth_o, 0);
    reset = 1'b0;
    tick();
    // nesting and return
    entry(4, 1, 8);
    entry(7, 7, 14);
    pc_in = 16'd100;
    pend(4);
    check("n1_take", take_o, 1);
    check("n1_pc", pc_out, 8);
    tick();
    check("n1_level", level_o, 1);
    check("n1_depth", depth_o, 1);
    pc_in = 16'd9;
    pend(7);
    check("n2_take", take_o, 1);
    check("n2_pc", pc_out, 14);
    tick();
    check("n2_level", level_o, 7);
    check("n2_depth", depth_o, 2);
    mret_i = 1'b1;
    #1;
    check("n3_take", take_o, 0);
    check("n3_pc", pc_out, 9);
    tick();
    mret_i = 1'b0;
    #1;
    check("n3_level", level_o, 1);
    check("n3_depth", depth_o, 1);
    // tail-chain inside the vec4 handler
    entry(2, 2, 4);
    pend_i[2] = 1'b1;
    tick();
    pend_i = '0;
    mret_i = 1'b1;
    #1;
    check("tc_take", take_o, 1);
    check("tc_pc", pc_out, 4);
    tick();
    mret_i = 1'b0;
    #1;
    check("tc_depth", depth_o, 1);
    check("tc_level", level_o, 2);
    mret_i = 1'b1;
    #1;
    check("tc_pop_pc", pc_out, 100);
    tick();
    mret_i = 1'b0;
    #1;
    check("tc_pop_level", level_o, 0);
    check("tc_pop_depth", depth_o, 0);
    // arbitration tie goes to the lower index
    entry(0, 1, 20);
    pc_in = 16'd50;
    pend_i = 16'h0011;
    tick();
    pend_i = '0;
    #1;
    check("arb_take", take_o, 1);
    check("arb_pc", pc_out, 20);
    tick();
    mret_i = 1'b1;
    #1;
    check("arb_chain_pc", pc_out, 8);
    tick();
    #1;
    check("arb_pop_pc", pc_out, 50);
    tick();
    mret_i = 1'b0;
    #1;
    check("arb_depth", depth_o, 0);
    // threshold gating
    cfg_wr(2'd2, 0, 7);
    pc_in = 16'd60;
    pend(7);
    check("thr7_take", take_o, 0);
    cfg_wr(2'd2, 0, 6);
    #1;
    check("thr6_take", take_o, 1);
    check("thr6_pc", pc_out, 14);
    tick();
    check("thr6_level", level_o, 7);
    mret_i = 1'b1;
    #1;
    check("thr_pop_pc", pc_out, 60);
    tick();
    mret_i = 1'b0;
    cfg_wr(2'd2, 0, 0);
    // stack full
    for (int k = 0; k < 4; k++) begin
      entry(4'(8 + k), 3'(1 + k), 16'(40 + k));
    end
    entry(12, 5, 50);
    for (int k = 0; k < 4; k++) begin
      pc_in = 16'(200 + k);
      pend(8 + k);
      check("full_push_pc", pc_out, 40 + k);
      tick();
    end
    check("full_depth", depth_o, 4);
    check("full_level", level_o, 4);
    pc_in = 16'd300;
    pend(12);
    check("full_take", take_o, 0);
    check("full_pc", pc_out, 300);
    cfg_rd(2'd0, 12);
    check("full_pending", rd, 32'd23);
    mret_i = 1'b1;
    #1;
    check("full_chain_take", take_o, 1);
    check("full_chain_pc", pc_out, 50);
    tick();
    check("full_chain_depth", depth_o, 4);
    check("full_chain_level", level_o, 5);
    for (int k = 3; k >= 0; k--) begin
      check("full_pop_pc", pc_out, 200 + k);
      tick();
      check("full_pop_level", level_o, k);
    end
    mret_i = 1'b0;
    #1;
    check("full_pop_depth", depth_o, 0);
    // error on empty mret
    pc_in = 16'd77;
    mret_i = 1'b1;
    #1;
    check("err_pc", pc_out, 77);
    check("err_take", take_o, 0);
    tick();
    mret_i = 1'b0;
    #1;
    check("err_flag", err_o, 1);
    // re-pend on take keeps pending
    entry(3, 3, 30);
    pend(3);
    check("cf1_take", take_o, 1);
    pend(3);
    check("cf1_depth", depth_o, 1);
    cfg_rd(2'd0, 3);
    check("cf1_entry", rd, 32'd15);
    mret_i = 1'b1;
    #1;
    check("cf1_chain_pc", pc_out, 30);
    tick();
    #1;
    check("cf1_pop_pc", pc_out, 77);
    tick();
    mret_i = 1'b0;
    // cfg write beats pend and take
    pend(3);
    check("cf2_take", take_o, 1);
    c.cfg_we = 1'b1;
    c.cfg_field = 2'd0;
    c.cfg_idx = 4'd3;
    c.cfg_wdata = 32'd0;
    pend_i[3] = 1'b1;
    tick();
    c.cfg_we = 1'b0;
    pend_i = '0;
    cfg_rd(2'd0, 3);
    check("cf2_entry", rd, 32'd0);
    mret_i = 1'b1;
    tick();
    mret_i = 1'b0;
    // reset mid-operation
    entry(9, 2, 41);
    pend(9);
    tick();
    pend(12);
    tick();
    check("mid_depth", depth_o, 2);
    check("mid_level", level_o, 5);
    pc_in = 16'd123;
    #2 reset = 1'b1;
    #1;
    check("mr_depth", depth_o, 0);
    check("mr_level", level_o, 0);
    check("mr_err", err_o, 0);
    check("mr_take", take_o, 0);
    check("mr_pc", pc_out, 123);
    cfg_rd(2'd0, 12);
    check("mr_entry", rd, 0);
    cfg_rd(2'd1, 12);
    check("mr_addr", rd, 0);
    tick();
    reset = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/n_clic_tc.md
Name: n_clic_tc

Overview:
- Parametrised successor of the n_clic nested vectored interrupt controller.
- Adds configurable vector count, priority width and nesting depth; a hardware return stack of {pc, level}; tail-chaining on mret; a stack-full inhibit; and a simple indexed config port.
- Sits beside the fetch stage: pc_out drives the pc register, whose output returns as pc_in.

Parameters:
- VecCount, 16, number of interrupt vectors (power of 2, ≥2).
- PrioWidth, 3, priority/level width; level 0 = thread mode.
- StackDepth, 4, maximum nesting depth (entries in return stack).
- PcWidth, 16, instruction address width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- pend_i  in  VecCount  per-vector pend pulse; sets pending on rising clk edge
- cfg_we  in  1  config write enable
- cfg_idx  in  $clog2(VecCount)  vector index
- cfg_field  in  2  0=entry {prio,enable,pending}, 1=vector address, 2=threshold (idx ignored), 3=reserved
- cfg_wdata  in  32  write data; entry layout bit0 pending, bit1 enable, bits[2+:PrioWidth] prio
- cfg_rdata  out  32  combinational read of {cfg_idx,cfg_field}, zero-extended; reserved reads 0
- pc_in  in  PcWidth  current pc (address to resume at if preempted)
- mret_i  in  1  current instruction is mret
- pc_out  out  PcWidth  next pc
- take_o  out  1  vector taken this cycle
- level_o  out  PrioWidth  current running level
- depth_o  out  $clog2(StackDepth+1)  stack occupancy
- err_o  out  1  sticky: mret with empty stack

Behaviour:
- Reset (async): all entries, vector addresses, threshold, level, depth, stack, err_o = 0. Outputs: take_o=0, pc_out=pc_in, cfg_rdata per state (0).
- Arbitration (combinational, from registered state): candidates are vectors with pending&enable. Select max prio; ties go to lowest index. Produces max_prio and max_vec.
- Effective level eff = max(level, threshold).
- Preempt (not mret_i): when a candidate exists, max_prio > eff and depth < StackDepth:
  - take_o=1, pc_out=vec_addr[max_vec].
  - At the edge: push {pc_in, level}, depth+1, level := max_prio, clear pending[max_vec].
- Stack full: depth == StackDepth inhibits preemption. The interrupt stays pending; no error is raised.
- mret_i with depth>0: the restored level r = top.level.
  - Tail-chain: if a candidate has max_prio > max(r, threshold), take_o=1 and pc_out=vec_addr[max_vec]. Stack and depth are unchanged (the saved pc is reused); level := max_prio; clear pending[max_vec].
  - Otherwise pop: pc_out=top.pc, level := r, depth-1, take_o=0.
- mret_i with depth==0: pc_out=pc_in, take_o=0, err_o := 1 (sticky until reset); state otherwise unchanged.
- No event: pc_out=pc_in, take_o=0.
- Latency: the decision is combinational in the same cycle. The new level is visible from the next cycle. A pend_i pulse becomes eligible one cycle after its edge.
- Same-cycle pending conflicts, per vector, in priority order: cfg write to the entry wins over everything; then pend_i set wins over clear-on-take. A taken vector that is re-pended in the same cycle stays pending.
- Threshold raise while nested: running handlers are unaffected; only new preemption uses the new threshold.
- prio 0 vectors can never be taken, since eff ≥ 0.
- Vector address is used verbatim as pc_out (units as the fetch stage, words).

Test Plan:
- Reset mid-operation: depth=2, level=5, then reset → depth 0, level 0, err 0, all entries 0, pc_out=pc_in, take_o=0.
- Nesting and return:
  - Vec4 prio1 addr 8 pending, pc_in=100 → take_o=1, pc_out=8; next cycle level=1, depth=1.
  - Vec7 prio7 addr 14 pended at pc_in=9 → pc_out=14, depth=2, level=7.
  - mret → pc_out=9, level=1, depth=1.
- Tail-chain: in a vec4 handler (depth 1, stack pc 100), vec2 prio2 addr 4 pends, plus mret the same cycle → take_o=1, pc_out=4, depth 1, level 2. The following mret → pc_out=100, level 0, depth 0.
- Arbitration and threshold:
  - Vec0 and vec4 both prio1 pending → vec0 taken.
  - Threshold=7 with vec7 prio7 pending → no take.
  - Threshold lowered to 6 → take vec7.
- Stack full: StackDepth=4, four nested takes prio 1..4, vec prio5 pends → take_o=0, pending kept. After mret → vec taken via tail-chain, pc_out=its address.
- Errors and conflicts:
  - mret at depth 0 → err_o=1, pc_out=pc_in.
  - pend_i[3] asserted the same cycle vec3 is taken → pending[3] reads 1 via cfg_rdata.
  - cfg write of 0 to entry 3 the same cycle → pending[3] reads 0.
